// File: rtl/control_cmd_dispatch_pkg.sv
// control_cmd_dispatch_pkg: calc_pkg watchdog width helper and commands_pkg opcode table with slot lookup
package calc_pkg;
  function automatic int wd_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction
endpackage

package commands_pkg;
  typedef logic [7:0] cmd_opcode_t;
  localparam int NUM_OPCODES = 4;
  localparam int SLOT_W = 2;
  typedef struct packed {
    logic hit;
    logic [SLOT_W-1:0] index;
  } slot_lookup_t;
  localparam logic [NUM_OPCODES-1:0][7:0] OPCODE_TABLE = {8'h54, 8'h46, 8'h50, 8'h52};
  function automatic slot_lookup_t opcode_to_slot(input cmd_opcode_t op);
    slot_lookup_t r;
    r = '0;
    for (int i = 0; i < NUM_OPCODES; i++)
      if (op == OPCODE_TABLE[i]) r = '{hit: 1'b1, index: SLOT_W'(i)};
    return r;
  endfunction
endpackage

// File: rtl/control_cmd_dispatch_if.sv
// control_cmd_dispatch_if: byte stream in, sub-command strobes/done and status out of the dispatcher
interface control_cmd_dispatch_if #(parameter int NUM_SUBCMDS = 4);
  localparam int SEL_W = NUM_SUBCMDS > 1 ? $clog2(NUM_SUBCMDS) : 1;
  logic [7:0] data_in;
  logic data_valid;
  logic [NUM_SUBCMDS-1:0] sub_enable;
  logic [7:0] sub_data;
  logic [NUM_SUBCMDS-1:0] sub_done;
  logic [SEL_W-1:0] active_sel;
  logic busy;
  logic cmd_done;
  logic cmd_error;
  modport slave (
    input data_in, data_valid, sub_done,
    output sub_enable, sub_data, active_sel, busy, cmd_done, cmd_error
  );
  modport master (
    output data_in, data_valid, sub_done,
    input sub_enable, sub_data, active_sel, busy, cmd_done, cmd_error
  );
endinterface

// File: rtl/control_cmd_dispatch_watchdog.sv
// cmd_watchdog: saturating inactivity counter, expired once TIMEOUT_CYCLES idle cycles have elapsed
module cmd_watchdog
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int W = wd_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : (run && cnt_q != LIMIT) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = cnt_q == LIMIT;
endmodule

// File: rtl/control_cmd_dispatch.sv
// control_cmd_dispatch: opcode decode and payload strobe dispatch; CMD_DISPATCH_TIMEOUT_EN adds an inactivity watchdog
module control_cmd_dispatch
  import commands_pkg::*;
#(
  parameter int NUM_SUBCMDS = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic reset_n,
  control_cmd_dispatch_if.slave bus
);
  localparam int SEL_W = NUM_SUBCMDS > 1 ? $clog2(NUM_SUBCMDS) : 1;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [NUM_SUBCMDS-1:0] sub_enable_q, sub_enable_d;
  logic [7:0] sub_data_q, sub_data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic cmd_done_q, cmd_done_d, cmd_error_q, cmd_error_d;
  logic expired, hit, done_act, decode;
  slot_lookup_t lk;
`ifdef CMD_DISPATCH_TIMEOUT_EN
  cmd_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk),
    .reset_n(reset_n),
    .clear(bus.data_valid || state_q == IDLE),
    .run(state_q == ACTIVE),
    .expired(expired)
  );
`else
  assign expired = TIMEOUT_CYCLES < 0;
`endif
  assign lk = opcode_to_slot(bus.data_in);
  assign hit = lk.hit && int'(lk.index) < NUM_SUBCMDS;
  assign done_act = state_q == ACTIVE && bus.sub_done[sel_q];
  assign decode = bus.data_valid && (state_q == IDLE || done_act);
  always_comb begin
    state_d = done_act ? IDLE : state_q;
    sel_d = sel_q;
    sub_data_d = sub_data_q;
    sub_enable_d = '0;
    cmd_done_d = done_act;
    cmd_error_d = 1'b0;
    if (decode) begin
      state_d = hit ? ACTIVE : state_d;
      sel_d = hit ? SEL_W'(lk.index) : sel_q;
      cmd_error_d = !hit && !done_act;
    end else if (bus.data_valid) begin
      sub_enable_d = NUM_SUBCMDS'(1) << sel_q;
      sub_data_d = bus.data_in;
    end else if (state_q == ACTIVE && !done_act && expired) begin
      state_d = IDLE;
      cmd_error_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      sub_data_q <= '0;
      sub_enable_q <= '0;
      cmd_done_q <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      sub_data_q <= sub_data_d;
      sub_enable_q <= sub_enable_d;
      cmd_done_q <= cmd_done_d;
      cmd_error_q <= cmd_error_d;
    end
  assign bus.sub_enable = sub_enable_q;
  assign bus.sub_data = sub_data_q;
  assign bus.active_sel = sel_q;
  assign bus.busy = state_q == ACTIVE;
  assign bus.cmd_done = cmd_done_q;
  assign bus.cmd_error = cmd_error_q;
endmodule
